rollingsum_multi: RTL and testbench

ROLLINGSUM_MULTI -- requirements
Module: rollingsum_multi

---
 rtl/rollingsum_multi.sv | 128 ++++++++++++
 tb/tb_rollingsum_multi.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rollingsum_multi.sv
// Multi-channel sliding-window sum and mean over the last 2^k accepted ADC
// samples, with per-channel trigger pause, shared external pause and override.
module rollingsum_multi #(
    parameter int SAMPLEBITS  = 12,
    parameter int ADDRBITS    = 7,
    parameter int CHANNELS    = 4,
    parameter int INPUT_DELAY = 5
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [CHANNELS*SAMPLEBITS-1:0]             d_in,
    input  logic [CHANNELS-1:0]                        trig,
    input  logic                                       pause,
    input  logic                                       pause_ovr,
    input  logic [2:0]                                 len_log2,
    input  logic [15:0]                                pause_len,
    output logic [CHANNELS*(SAMPLEBITS+ADDRBITS)-1:0]  sum_out,
    output logic [CHANNELS*SAMPLEBITS-1:0]             baseline,
    output logic [CHANNELS-1:0]                        valid
);
    localparam int SUMBITS = SAMPLEBITS + ADDRBITS;
    localparam int KBITS   = $clog2(ADDRBITS + 1);
    localparam int DEPTH   = 2 ** ADDRBITS;

    typedef enum logic {
        FILLING = 1'b0,
        ROLLING = 1'b1
    } state_t;

    function automatic logic [KBITS-1:0] clamp_k(input logic [2:0] v);
        logic [31:0] vi;
        vi = {29'd0, v};
        if (vi == 32'd0) begin
            return KBITS'(1);
        end else if (vi > 32'(ADDRBITS)) begin
            return KBITS'(ADDRBITS);
        end else begin
            return KBITS'(vi);
        end
    endfunction

    logic [KBITS-1:0]  k_r      = KBITS'(1);
    logic [KBITS-1:0]  k_prev_r = KBITS'(1);
    logic              restart_s;
    logic [ADDRBITS:0] len_s;

    // Window exponent register; a change is seen as restart on the following clock.
    always_ff @(posedge clk) begin
        k_r      <= clamp_k(len_log2);
        k_prev_r <= k_r;
    end

    assign restart_s = (k_r != k_prev_r);
    assign len_s     = (ADDRBITS+1)'(1) << k_r;

    logic [CHANNELS*SAMPLEBITS-1:0] dly_r [INPUT_DELAY] = '{default: '0};

    // Input alignment pipeline, intentionally left untouched by rst.
    always_ff @(posedge clk) begin
        dly_r[0] <= d_in;
        for (int i = 1; i < INPUT_DELAY; i++) begin
            dly_r[i] <= dly_r[i-1];
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [SAMPLEBITS-1:0] mem_r [DEPTH] = '{default: '0};
        logic [SAMPLEBITS-1:0] d_dly_s;
        logic [SAMPLEBITS-1:0] oldest_s;
        logic [ADDRBITS-1:0]   rd_addr_s;
        logic [ADDRBITS-1:0]   last_s;
        logic                  paused_s;
        logic [SUMBITS-1:0]    sum_r   = '0;
        logic [ADDRBITS-1:0]   wp_r    = '0;
        logic [15:0]           pcnt_r  = '0;
        state_t                state_r = FILLING;

        assign d_dly_s   = dly_r[INPUT_DELAY-1][c*SAMPLEBITS +: SAMPLEBITS];
        assign paused_s  = (pause | (pcnt_r != 16'd0)) & ~pause_ovr;
        // Oldest sample sits L accepted writes behind the write pointer.
        assign rd_addr_s = ADDRBITS'({1'b0, wp_r} - len_s);
        assign last_s    = ADDRBITS'(len_s - (ADDRBITS+1)'(1));
        assign oldest_s  = mem_r[rd_addr_s];

        // Sample buffer; only accepted samples are stored.
        always_ff @(posedge clk) begin
            if (!rst && !restart_s && !paused_s) begin
                mem_r[wp_r] <= d_dly_s;
            end
        end

        // Trigger pause counter, window sum, write pointer and fill state.
        always_ff @(posedge clk) begin
            if (rst) begin
                sum_r   <= '0;
                wp_r    <= '0;
                pcnt_r  <= '0;
                state_r <= FILLING;
            end else begin
                if (trig[c]) begin
                    pcnt_r <= pause_len;
                end else if (pcnt_r != 16'd0) begin
                    pcnt_r <= pcnt_r - 16'd1;
                end

                if (restart_s) begin
                    sum_r   <= '0;
                    wp_r    <= '0;
                    state_r <= FILLING;
                end else if (!paused_s) begin
                    wp_r <= wp_r + ADDRBITS'(1);
                    if (state_r == FILLING) begin
                        sum_r <= sum_r + SUMBITS'(d_dly_s);
                        if (wp_r == last_s) begin
                            state_r <= ROLLING;
                        end
                    end else begin
                        sum_r <= sum_r + SUMBITS'(d_dly_s) - SUMBITS'(oldest_s);
                    end
                end
            end
        end

        assign sum_out[c*SUMBITS +: SUMBITS]        = sum_r;
        assign baseline[c*SAMPLEBITS +: SAMPLEBITS] = SAMPLEBITS'(sum_r >> k_r);
        assign valid[c]                             = (state_r == ROLLING);
    end
endmodule

// File: tb/tb_rollingsum_multi.sv
// Bench for rollingsum_multi: directed scenarios and random traffic, checked
// every cycle against a queue-based window model plus literal expectations.
module tb_rollingsum_multi;
    localparam int SB = 12;
    localparam int AB = 7;
    localparam int CH = 4;
    localparam int D  = 5;
    localparam int SW = SB + AB;

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic [CH*SB-1:0] d_in      = '0;
    logic [CH-1:0]    trig      = '0;
    logic             pause     = 1'b0;
    logic             pause_ovr = 1'b0;
    logic [2:0]       len_log2  = 3'd3;
    logic [15:0]      pause_len = 16'd0;
    logic [CH*SW-1:0] sum_out;
    logic [CH*SB-1:0] baseline;
    logic [CH-1:0]    valid;

    int n_tests = 0;
    int n_fail  = 0;

    rollingsum_multi #(
        .SAMPLEBITS (SB),
        .ADDRBITS   (AB),
        .CHANNELS   (CH),
        .INPUT_DELAY(D)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .d_in     (d_in),
        .trig     (trig),
        .pause    (pause),
        .pause_ovr(pause_ovr),
        .len_log2 (len_log2),
        .pause_len(pause_len),
        .sum_out  (sum_out),
        .baseline (baseline),
        .valid    (valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input bit ok, input longint act, input longint exp);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    function automatic longint sum_of(input int c);
        return longint'(sum_out[c*SW +: SW]);
    endfunction

    function automatic longint base_of(input int c);
        return longint'(baseline[c*SB +: SB]);
    endfunction

    function automatic int clampk(input logic [2:0] v);
        if (v == 3'd0) return 1;
        return (int'(v) > AB) ? AB : int'(v);
    endfunction

    // Reference model: input history queue, accepted-sample window queue per channel.
    int unsigned hq [CH][$];
    int unsigned wq [CH][$];
    bit          mfull [CH];
    longint      pend [CH];
    int          mk  = 1;
    int          mkp = 1;
    longint      cyc = 0;

    initial begin
        bit          rs;
        bit          pz;
        int          len;
        int unsigned dd;
        for (int c = 0; c < CH; c++) begin
            for (int i = 0; i < D; i++) hq[c].push_back(0);
            mfull[c] = 1'b0;
            pend[c]  = -1;
        end
        forever begin
            @(posedge clk);
            rs  = (mk != mkp);
            len = 1 << mk;
            for (int c = 0; c < CH; c++) begin
                dd = hq[c].pop_front();
                hq[c].push_back(int'(d_in[c*SB +: SB]));
                if (rst) begin
                    wq[c].delete();
                    mfull[c] = 1'b0;
                    pend[c]  = -1;
                end else begin
                    pz = (pause || (cyc <= pend[c])) && !pause_ovr;
                    if (trig[c]) pend[c] = cyc + longint'(pause_len);
                    if (rs) begin
                        wq[c].delete();
                        mfull[c] = 1'b0;
                    end else if (!pz) begin
                        wq[c].push_back(dd);
                        if (wq[c].size() > len) void'(wq[c].pop_front());
                        if (wq[c].size() == len) mfull[c] = 1'b1;
                    end
                end
            end
            mkp = mk;
            mk  = clampk(len_log2);
            cyc++;
        end
    end

    // Every-cycle comparison of all channels against the model.
    initial begin
        longint s;
        longint b;
        forever begin
            @(negedge clk);
            for (int c = 0; c < CH; c++) begin
                s = 0;
                for (int i = 0; i < wq[c].size(); i++) s += longint'(wq[c][i]);
                b = (s >> mk) & 64'd4095;
                check($sformatf("model_sum[%0d]", c), sum_of(c) == s, sum_of(c), s);
                check($sformatf("model_base[%0d]", c), base_of(c) == b, base_of(c), b);
                check($sformatf("model_valid[%0d]", c), valid[c] == mfull[c],
                      longint'(valid[c]), longint'(mfull[c]));
            end
        end
    end

    bit          ramp_on  = 1'b0;
    bit          rand_on  = 1'b0;
    bit          rand0_on = 1'b0;
    int unsigned ramp     = 1000;

    task automatic set_all(input int unsigned v);
        for (int c = 0; c < CH; c++) d_in[c*SB +: SB] = SB'(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        ramp = (ramp + 1) % 4096;
        if (rand_on) begin
            for (int c = 0; c < CH; c++) d_in[c*SB +: SB] = SB'($urandom_range(0, 4095));
        end
        if (rand0_on) d_in[0 +: SB] = SB'($urandom_range(0, 4095));
        if (ramp_on) d_in[SB +: SB] = SB'(ramp);
    endtask

    initial begin
        longint s0;
        longint sp;
        longint ex;

        set_all(0);
        repeat (5) tick();
        @(negedge clk);
        for (int c = 0; c < CH; c++) begin
            check("reset_sum", sum_of(c) == 0, sum_of(c), 0);
            check("reset_base", base_of(c) == 0, base_of(c), 0);
            check("reset_valid", valid[c] == 1'b0, longint'(valid[c]), 0);
        end

        rst = 1'b0;
        set_all(100);
        repeat (30) tick();
        @(negedge clk);
        for (int c = 0; c < CH; c++) begin
            check("const100_sum", sum_of(c) == 800, sum_of(c), 800);
            check("const100_base", base_of(c) == 100, base_of(c), 100);
            check("const100_valid", valid[c] == 1'b1, longint'(valid[c]), 1);
        end

        tick();
        set_all(200);
        repeat (D + 1) tick();
        @(negedge clk);
        check("step_first", sum_of(0) == 900, sum_of(0), 900);
        for (int i = 2; i <= 10; i++) begin
            tick();
            @(negedge clk);
            ex = (i <= 8) ? 800 + 100 * i : 1600;
            check("step_ramp", sum_of(0) == ex, sum_of(0), ex);
        end

        rand0_on = 1'b1;
        ramp_on  = 1'b1;
        repeat (20) tick();
        pause_len = 16'd10;
        trig      = 4'b0010;
        tick();
        trig = '0;
        @(negedge clk);
        s0 = sum_of(1);
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge clk);
            check("pause_hold", sum_of(1) == s0, sum_of(1), s0);
        end
        tick();
        @(negedge clk);
        check("pause_resume", sum_of(1) > s0, sum_of(1), s0 + 1);

        pause_ovr = 1'b1;
        pause     = 1'b1;
        trig      = 4'b0010;
        tick();
        trig = '0;
        @(negedge clk);
        sp = sum_of(1);
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge clk);
            check("ovr_no_freeze", sum_of(1) > sp, sum_of(1), sp + 1);
            sp = sum_of(1);
        end
        pause     = 1'b0;
        pause_ovr = 1'b0;

        rand0_on = 1'b0;
        ramp_on  = 1'b0;
        set_all(100);
        repeat (20) tick();
        len_log2 = 3'd4;
        tick();
        @(negedge clk);
        check("kchg_valid_hold", valid[0] == 1'b1, longint'(valid[0]), 1);
        check("kchg_base_newk", base_of(0) == 50, base_of(0), 50);
        tick();
        @(negedge clk);
        check("kchg_valid_drop", valid[0] == 1'b0, longint'(valid[0]), 0);
        check("kchg_sum_clear", sum_of(0) == 0, sum_of(0), 0);
        repeat (15) tick();
        @(negedge clk);
        check("kchg_fill15_valid", valid[0] == 1'b0, longint'(valid[0]), 0);
        check("kchg_fill15_sum", sum_of(0) == 1500, sum_of(0), 1500);
        tick();
        @(negedge clk);
        check("kchg_full_valid", valid[0] == 1'b1, longint'(valid[0]), 1);
        check("kchg_full_sum", sum_of(0) == 1600, sum_of(0), 1600);
        check("kchg_full_base", base_of(0) == 100, base_of(0), 100);

        len_log2 = 3'd7;
        set_all(4095);
        repeat (150) tick();
        @(negedge clk);
        for (int c = 0; c < CH; c++) begin
            check("k7_sum", sum_of(c) == 524160, sum_of(c), 524160);
            check("k7_base", base_of(c) == 4095, base_of(c), 4095);
            check("k7_valid", valid[c] == 1'b1, longint'(valid[c]), 1);
        end
        len_log2 = 3'd0;
        repeat (8) tick();
        @(negedge clk);
        check("k0clamp_sum", sum_of(0) == 8190, sum_of(0), 8190);
        check("k0clamp_base", base_of(0) == 4095, base_of(0), 4095);
        check("k0clamp_valid", valid[0] == 1'b1, longint'(valid[0]), 1);

        len_log2 = 3'd3;
        set_all(100);
        repeat (30) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        for (int c = 0; c < CH; c++) begin
            check("rst_mid_sum", sum_of(c) == 0, sum_of(c), 0);
            check("rst_mid_base", base_of(c) == 0, base_of(c), 0);
            check("rst_mid_valid", valid[c] == 1'b0, longint'(valid[c]), 0);
        end
        repeat (7) tick();
        @(negedge clk);
        check("rst_refill7_valid", valid[0] == 1'b0, longint'(valid[0]), 0);
        check("rst_refill7_sum", sum_of(0) == 700, sum_of(0), 700);
        tick();
        @(negedge clk);
        check("rst_refill8_valid", valid[0] == 1'b1, longint'(valid[0]), 1);
        check("rst_refill8_sum", sum_of(0) == 800, sum_of(0), 800);

        rand_on = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            tick();
            rst   = ($urandom_range(0, 199) == 0);
            pause = ($urandom_range(0, 19) == 0);
            for (int c = 0; c < CH; c++) trig[c] = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 99) == 0) pause_ovr = ~pause_ovr;
            if ($urandom_range(0, 63) == 0) len_log2 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 31) == 0) pause_len = 16'($urandom_range(0, 20));
        end
        rst   = 1'b0;
        trig  = '0;
        pause = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
